// File: rtl/sentry_cmd_sequencer.sv
// Command sequencer: parses A5/CMD/ARG/CHK packets, slews the servo toward its target,
// and schedules armed trigger pulses with fixed on-time and cooldown.
module sentry_cmd_sequencer #(
    parameter int unsigned POS_HOME  = 128,
    parameter int unsigned POS_MIN   = 20,
    parameter int unsigned POS_MAX   = 230,
    parameter int unsigned SLEW_DIV  = 500000,
    parameter int unsigned STEP      = 2,
    parameter int unsigned FIRE_ON   = 2500000,
    parameter int unsigned FIRE_COOL = 25000000,
    parameter int unsigned TIMEOUT   = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] servo_pos,
    output logic       fire_pin,
    output logic       armed,
    output logic       busy,
    output logic [7:0] err_count
);
    localparam int SW = $clog2(SLEW_DIV);
    localparam int TW = $clog2(TIMEOUT);
    localparam int FW = $clog2((FIRE_COOL > FIRE_ON) ? FIRE_COOL : FIRE_ON);

    typedef enum logic [1:0] {P_SYNC, P_CMD, P_ARG, P_CHK} p_state_t;
    typedef enum logic [1:0] {F_IDLE, F_ON, F_COOL} f_state_t;

    p_state_t      p_state;
    f_state_t      f_state;
    logic [7:0]    cmd_q, arg_q, target;
    logic [3:0]    shots_left;
    logic [SW-1:0] slew_cnt;
    logic [TW-1:0] to_cnt;
    logic [FW-1:0] f_cnt;

    logic       pkt_done, chk_ok, exec, do_pos, do_fire, do_arm, do_abort, kill;
    logic       err_inc, timeout, settled, start;
    logic [3:0] shots_dec, shots_nxt;
    logic [4:0] shots_sum;
    logic [7:0] pos_clamped;

    always_comb begin
        pkt_done  = rx_valid && (p_state == P_CHK);
        chk_ok    = (rx_byte == (cmd_q ^ arg_q));
        exec      = pkt_done && chk_ok;
        do_pos    = exec && (cmd_q == 8'h01);
        do_fire   = exec && (cmd_q == 8'h02) && armed;
        do_arm    = exec && (cmd_q == 8'h03);
        do_abort  = exec && (cmd_q == 8'h04);
        kill      = (do_arm && !arg_q[0]) || do_abort;
        timeout   = (p_state != P_SYNC) && !rx_valid && (to_cnt == TW'(TIMEOUT - 1));
        err_inc   = (pkt_done && !chk_ok) || timeout
                  || (exec && (cmd_q == 8'h02) && !armed)
                  || (exec && (cmd_q == 8'h00 || cmd_q > 8'h04));
        settled   = (servo_pos == target);
        start     = (f_state == F_IDLE) && armed && (shots_left != 4'd0) && settled;
        // Command updates to shots_left land on top of this cycle's launch decrement
        shots_dec = shots_left - {3'b000, start};
        shots_sum = {1'b0, shots_dec} + {1'b0, arg_q[3:0]};
        shots_nxt = shots_dec;
        if (kill)
            shots_nxt = 4'd0;
        else if (do_fire)
            shots_nxt = (shots_sum > 5'd15) ? 4'd15 : shots_sum[3:0];
        pos_clamped = arg_q;
        if (arg_q < 8'(POS_MIN))
            pos_clamped = 8'(POS_MIN);
        else if (arg_q > 8'(POS_MAX))
            pos_clamped = 8'(POS_MAX);
    end

    assign busy = (shots_left != 4'd0) || (f_state != F_IDLE) || !settled;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            p_state    <= P_SYNC;
            f_state    <= F_IDLE;
            cmd_q      <= 8'h00;
            arg_q      <= 8'h00;
            target     <= 8'(POS_HOME);
            servo_pos  <= 8'(POS_HOME);
            shots_left <= 4'd0;
            slew_cnt   <= '0;
            to_cnt     <= '0;
            f_cnt      <= '0;
            fire_pin   <= 1'b0;
            armed      <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            if (timeout) begin
                p_state <= P_SYNC;
                to_cnt  <= '0;
            end else if (rx_valid) begin
                to_cnt <= '0;
                case (p_state)
                    P_SYNC: if (rx_byte == 8'hA5) p_state <= P_CMD;
                    P_CMD:  begin cmd_q <= rx_byte; p_state <= P_ARG; end
                    P_ARG:  begin arg_q <= rx_byte; p_state <= P_CHK; end
                    default: p_state <= P_SYNC;
                endcase
            end else if (p_state != P_SYNC) begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (do_arm)
                armed <= arg_q[0];
            shots_left <= shots_nxt;

            if (do_pos)
                target <= pos_clamped;
            else if (do_abort)
                target <= servo_pos;

            // Abort freezes the servo where it stands, so a coincident tick is dropped
            if (slew_cnt == SW'(SLEW_DIV - 1)) begin
                slew_cnt <= '0;
                if (!do_abort) begin
                    if (servo_pos < target)
                        servo_pos <= (target - servo_pos > 8'(STEP)) ? servo_pos + 8'(STEP) : target;
                    else if (servo_pos > target)
                        servo_pos <= (servo_pos - target > 8'(STEP)) ? servo_pos - 8'(STEP) : target;
                end
            end else begin
                slew_cnt <= slew_cnt + SW'(1);
            end

            case (f_state)
                F_IDLE: if (start) begin
                    f_state  <= F_ON;
                    fire_pin <= 1'b1;
                    f_cnt    <= '0;
                end
                F_ON: if (kill || f_cnt == FW'(FIRE_ON - 1)) begin
                    f_state  <= F_COOL;
                    fire_pin <= 1'b0;
                    f_cnt    <= '0;
                end else begin
                    f_cnt <= f_cnt + FW'(1);
                end
                // The F_IDLE launch cycle is the final low cycle of the cooldown
                default: if (f_cnt == FW'(FIRE_COOL - 2)) begin
                    f_state <= F_IDLE;
                    f_cnt   <= '0;
                end else begin
                    f_cnt <= f_cnt + FW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sentry_cmd_sequencer.sv
// Directed bench for sentry_cmd_sequencer with shortened timing parameters.
module tb_sentry_cmd_sequencer;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] servo_pos, err_count;
    logic       fire_pin, armed, busy;
    int checks = 0;
    int failures = 0;

    sentry_cmd_sequencer #(
        .SLEW_DIV(4), .STEP(2), .FIRE_ON(5), .FIRE_COOL(10), .TIMEOUT(50)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .servo_pos(servo_pos), .fire_pin(fire_pin), .armed(armed), .busy(busy),
        .err_count(err_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(k);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (servo_pos !== 8'd128) begin failures++; $display("FAIL reset_pos: got %0d want 128", servo_pos); end
        checks++; if (fire_pin !== 1'b0) begin failures++; $display("FAIL reset_fire: got %b want 0", fire_pin); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed: got %b want 0", armed); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err: got %0d want 0", err_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_slew;
        int idx = 0;
        int last = -1;
        logic [7:0] prev;
        send_pkt(8'h01, 8'h8A, 8'h8B);
        checks++; if (dut.target !== 8'd138) begin failures++; $display("FAIL slew_target: got %0d want 138", dut.target); end
        for (int c = 0; c < 80; c++) begin
            prev = servo_pos;
            tick();
            if (servo_pos !== prev) begin
                checks++; if (servo_pos !== 8'(130 + 2 * idx)) begin failures++; $display("FAIL slew_step%0d: got %0d want %0d", idx, servo_pos, 130 + 2 * idx); end
                if (idx > 0) begin
                    checks++; if (c - last !== 4) begin failures++; $display("FAIL slew_interval%0d: got %0d want 4", idx, c - last); end
                end
                last = c;
                idx++;
            end
        end
        checks++; if (idx !== 5) begin failures++; $display("FAIL slew_nsteps: got %0d want 5", idx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL slew_busy: got %b want 0", busy); end
    endtask

    task automatic test_fire;
        logic seen = 1'b0;
        logic prev;
        int npulse = 0;
        int hi = 0;
        int lo = 0;
        send_pkt(8'h02, 8'h03, 8'h01);
        checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL fire_disarmed_err: got %0d want 1", err_count); end
        repeat (20) begin tick(); if (fire_pin) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL fire_disarmed_pin: got %b want 0", seen); end
        send_pkt(8'h03, 8'h01, 8'h02);
        checks++; if (armed !== 1'b1) begin failures++; $display("FAIL fire_arm: got %b want 1", armed); end
        send_pkt(8'h02, 8'h03, 8'h01);
        checks++; if (dut.shots_left !== 4'd3) begin failures++; $display("FAIL fire_queued: got %0d want 3", dut.shots_left); end
        prev = fire_pin;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (fire_pin) begin
                if (!prev) begin
                    if (npulse > 0) begin
                        checks++; if (lo !== 10) begin failures++; $display("FAIL fire_low%0d: got %0d want 10", npulse, lo); end
                    end
                    npulse++;
                    hi = 1;
                end else hi++;
            end else begin
                if (prev) begin
                    checks++; if (hi !== 5) begin failures++; $display("FAIL fire_high%0d: got %0d want 5", npulse, hi); end
                    lo = 1;
                end else lo++;
            end
            prev = fire_pin;
        end
        checks++; if (npulse !== 3) begin failures++; $display("FAIL fire_npulse: got %0d want 3", npulse); end
        checks++; if (dut.shots_left !== 4'd0) begin failures++; $display("FAIL fire_shots_end: got %0d want 0", dut.shots_left); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fire_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_errors;
        send_pkt(8'h01, 8'h10, 8'h00);
        checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL err_badchk: got %0d want 2", err_count); end
        checks++; if (dut.target !== 8'd138) begin failures++; $display("FAIL err_badchk_target: got %0d want 138", dut.target); end
        send_pkt(8'h07, 8'h00, 8'h07);
        checks++; if (err_count !== 8'd3) begin failures++; $display("FAIL err_unknown: got %0d want 3", err_count); end
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (49) tick();
        checks++; if (err_count !== 8'd3) begin failures++; $display("FAIL timeout_early: got %0d want 3", err_count); end
        checks++; if (dut.p_state !== 2'd2) begin failures++; $display("FAIL timeout_early_state: got %0d want 2", dut.p_state); end
        tick();
        checks++; if (err_count !== 8'd4) begin failures++; $display("FAIL timeout_err: got %0d want 4", err_count); end
        checks++; if (dut.p_state !== 2'd0) begin failures++; $display("FAIL timeout_state: got %0d want 0", dut.p_state); end
        send_pkt(8'h03, 8'h00, 8'h03);
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL timeout_next_pkt: got %b want 0", armed); end
        checks++; if (err_count !== 8'd4) begin failures++; $display("FAIL timeout_next_err: got %0d want 4", err_count); end
    endtask

    task automatic test_disarm;
        logic seen = 1'b0;
        send_pkt(8'h03, 8'h01, 8'h02);
        send_pkt(8'h02, 8'h05, 8'h07);
        checks++; if (dut.shots_left !== 4'd5) begin failures++; $display("FAIL disarm_queued: got %0d want 5", dut.shots_left); end
        for (int c = 0; c < 5 && !fire_pin; c++) tick();
        checks++; if (fire_pin !== 1'b1) begin failures++; $display("FAIL disarm_pulse_start: got %b want 1", fire_pin); end
        send_pkt(8'h03, 8'h00, 8'h03);
        checks++; if (fire_pin !== 1'b0) begin failures++; $display("FAIL disarm_pin: got %b want 0", fire_pin); end
        checks++; if (dut.shots_left !== 4'd0) begin failures++; $display("FAIL disarm_shots: got %0d want 0", dut.shots_left); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL disarm_armed: got %b want 0", armed); end
        repeat (60) begin tick(); if (fire_pin) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL disarm_no_more: got %b want 0", seen); end
    endtask

    task automatic test_pos_settle;
        int t_set = -1;
        int t_fire = -1;
        send_pkt(8'h01, 8'hFF, 8'hFE);
        checks++; if (dut.target !== 8'd230) begin failures++; $display("FAIL clamp_high: got %0d want 230", dut.target); end
        send_pkt(8'h03, 8'h01, 8'h02);
        send_pkt(8'h02, 8'h01, 8'h03);
        for (int c = 0; c < 400 && t_fire < 0; c++) begin
            tick();
            if (servo_pos == 8'd230 && t_set < 0) t_set = c;
            if (fire_pin && t_fire < 0) t_fire = c;
        end
        checks++; if (t_set < 0 || t_fire < 0) begin failures++; $display("FAIL settle_seen: set=%0d fire=%0d want both >=0", t_set, t_fire); end
        checks++; if (t_fire - t_set !== 1) begin failures++; $display("FAIL settle_gap: got %0d want 1", t_fire - t_set); end
    endtask

    task automatic test_reset_mid;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (fire_pin !== 1'b0) begin failures++; $display("FAIL midreset_fire: got %b want 0", fire_pin); end
        checks++; if (servo_pos !== 8'd128) begin failures++; $display("FAIL midreset_pos: got %0d want 128", servo_pos); end
        checks++; if (armed !== 1'b0) begin failures++; $display("FAIL midreset_armed: got %b want 0", armed); end
        send_pkt(8'h01, 8'h05, 8'h04);
        checks++; if (dut.target !== 8'd20) begin failures++; $display("FAIL clamp_low: got %0d want 20", dut.target); end
    endtask

    task automatic test_err_saturate;
        for (int i = 0; i < 260; i++) send_pkt(8'h00, 8'h00, 8'h01);
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL err_saturate: got %0d want 255", err_count); end
    endtask

    initial begin
        test_reset();
        test_slew();
        test_fire();
        test_errors();
        test_disarm();
        test_pos_settle();
        test_reset_mid();
        test_err_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
